// File: rtl/iir_pkg.sv
// Shared constants, types and helpers for the multi-channel biquad filter.
package iir_pkg;

  localparam int unsigned WIDTH_DEF = 13;
  localparam int unsigned FRAC_DEF  = WIDTH_DEF - 1;

  typedef struct packed {
    logic signed [63:0] value;
    logic               flag;
  } limit_t;

  function automatic int unsigned iir_ch_w(input int unsigned channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

  // Clamps to the signed range of 'width' bits when sat=1; otherwise passes the
  // value through and the caller keeps only the low 'width' bits (wrap).
  function automatic limit_t iir_limit(input logic signed [63:0] v,
                                       input int unsigned width,
                                       input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    limit_t r;
    hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (width - 1));
    r.flag  = (v > hi) || (v < lo);
    r.value = v;
    if (sat && (v > hi))      r.value = hi;
    else if (sat && (v < lo)) r.value = lo;
    return r;
  endfunction

endpackage

// File: rtl/iir_biquad_mc_mac.sv
// Signed 3-term multiply-accumulate: x +/- sum((c_i*d_i) >>> FRAC), limited to WIDTH bits.
module iir_mac3
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned FRAC     = WIDTH - 1,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] c0,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] c2,
  input  logic [WIDTH-1:0] d2,
  input  logic             sub,
  output logic [WIDTH-1:0] y,
  output logic             flag
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 2;

  logic signed [PW-1:0] m0, m1, m2;
  logic signed [SW-1:0] p0, p1, p2, bias, sum;
  limit_t               lim;

  always_comb begin
    m0   = $signed(c0) * $signed(d0);
    m1   = $signed(c1) * $signed(d1);
    m2   = $signed(c2) * $signed(d2);
    p0   = SW'(m0 >>> FRAC);
    p1   = SW'(m1 >>> FRAC);
    p2   = SW'(m2 >>> FRAC);
    bias = SW'($signed(x));
    sum  = sub ? (bias - p0 - p1 - p2) : (bias + p0 + p1 + p2);
    lim  = iir_limit({{(64 - SW){sum[SW-1]}}, sum}, WIDTH, SATURATE);
    y    = lim.value[WIDTH-1:0];
    flag = lim.flag;
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed direct-form-II biquad: per-channel state, shared 2-stage datapath.
module iir_biquad_mc
  import iir_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned FRAC     = WIDTH - 1,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = iir_ch_w(CHANNELS),
  parameter bit          SATURATE = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             CLR,
  input  logic             VIN,
  input  logic [WIDTH-1:0] DIN,
  input  logic [CH_W-1:0]  CH_IN,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  output logic             VOUT,
  output logic [WIDTH-1:0] DOUT,
  output logic [CH_W-1:0]  CH_OUT,
  output logic             SAT_FLAG
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic             s0_valid;
  logic [CH_W-1:0]  s0_ch;
  logic [WIDTH-1:0] s0_x, s0_a1, s0_a2, s0_b0, s0_b1, s0_b2;

  logic             s1_valid, s1_flag;
  logic [CH_W-1:0]  s1_ch;
  logic [WIDTH-1:0] s1_w, s1_w1, s1_w2, s1_b0, s1_b1, s1_b2;

  logic [WIDTH-1:0] w1_mem [CHANNELS];
  logic [WIDTH-1:0] w2_mem [CHANNELS];

  logic [CH_W-1:0]  rd_idx;
  logic [WIDTH-1:0] w1_rd, w2_rd, w_new, y_new;
  logic             w_flag, y_flag, accept;

  always_comb begin
    accept = VIN && ({1'b0, CH_IN} < CH_LIMIT);
    rd_idx = '0;
    if ({1'b0, s0_ch} < CH_LIMIT) rd_idx = s0_ch;
    w1_rd = w1_mem[rd_idx];
    w2_rd = w2_mem[rd_idx];
  end

  iir_mac3 #(.WIDTH(WIDTH), .FRAC(FRAC), .SATURATE(SATURATE)) u_mac_w (
    .x(s0_x), .c0('0), .d0('0), .c1(s0_a1), .d1(w1_rd), .c2(s0_a2), .d2(w2_rd),
    .sub(1'b1), .y(w_new), .flag(w_flag)
  );

  iir_mac3 #(.WIDTH(WIDTH), .FRAC(FRAC), .SATURATE(SATURATE)) u_mac_y (
    .x('0), .c0(s1_b0), .d0(s1_w), .c1(s1_b1), .d1(s1_w1), .c2(s1_b2), .d2(s1_w2),
    .sub(1'b0), .y(y_new), .flag(y_flag)
  );

  // The state write at the S1 edge is what the next captured sample reads,
  // so back-to-back samples on one channel need no forwarding.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      s0_valid <= 1'b0;
      s0_ch    <= '0;
      s0_x     <= '0;
      s0_a1    <= '0;
      s0_a2    <= '0;
      s0_b0    <= '0;
      s0_b1    <= '0;
      s0_b2    <= '0;
      s1_valid <= 1'b0;
      s1_flag  <= 1'b0;
      s1_ch    <= '0;
      s1_w     <= '0;
      s1_w1    <= '0;
      s1_w2    <= '0;
      s1_b0    <= '0;
      s1_b1    <= '0;
      s1_b2    <= '0;
      VOUT     <= 1'b0;
      DOUT     <= '0;
      CH_OUT   <= '0;
      SAT_FLAG <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        w1_mem[i] <= '0;
        w2_mem[i] <= '0;
      end
    end else if (CLR) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      VOUT     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        w1_mem[i] <= '0;
        w2_mem[i] <= '0;
      end
    end else begin
      s0_valid <= accept;
      s0_ch    <= CH_IN;
      s0_x     <= DIN;
      s0_a1    <= A1;
      s0_a2    <= A2;
      s0_b0    <= B0;
      s0_b1    <= B1;
      s0_b2    <= B2;

      if (s0_valid) begin
        w1_mem[rd_idx] <= w_new;
        w2_mem[rd_idx] <= w1_rd;
      end
      s1_valid <= s0_valid;
      s1_flag  <= w_flag;
      s1_ch    <= s0_ch;
      s1_w     <= w_new;
      s1_w1    <= w1_rd;
      s1_w2    <= w2_rd;
      s1_b0    <= s0_b0;
      s1_b1    <= s0_b1;
      s1_b2    <= s0_b2;

      VOUT <= s1_valid;
      if (s1_valid) begin
        DOUT     <= y_new;
        CH_OUT   <= s1_ch;
        SAT_FLAG <= s1_flag | y_flag;
      end
    end
  end

endmodule
